serial_add_sub: RTL and testbench

Bit-serial two's-complement adder/subtractor that drives one 1-bit full-adder cell per clock, LSB first, with a carry flip-flop closing the loop. It sits directly downstream of the team's FULL_ADDER cell and gives the ALU a low-area add/sub path. That path trades WIDTH+1 cycles of latency for a single adder cell. The block uses a START/DONE handshake and latches its result and status flags for the ALU result mux.

---
 rtl/serial_add_sub_pkg.sv | 16 +
 rtl/serial_add_sub_full_adder.sv | 16 +
 rtl/serial_add_sub.sv | 139 +++++++++++++
 tb/tb_serial_add_sub.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: default width,
// FSM state encodings and opcode values.
package serial_add_sub_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SAS_IDLE = 2'b00,
    SAS_RUN  = 2'b01,
    SAS_FIN  = 2'b10
  } sas_state_e;

  localparam logic SAS_OP_ADD = 1'b0;
  localparam logic SAS_OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full-adder cell; the only arithmetic in the serial sum path.
module serial_add_sub_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement add/sub, LSB first, one full-adder cell per clock.
// START/DONE handshake; result and flags are held until the next completion.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sas_state_e       state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg, res_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             c_reg;
  logic [WIDTH-1:0] y_reg;
  logic             co_reg, ovf_reg, zero_reg;

  logic             accept;
  logic             shift_en;
  logic             last_bit;
  logic [WIDTH-1:0] sb_load;
  logic             s_bit, co_bit, cmsb;
  logic [WIDTH-1:0] res_final;

  // Subtract loads ~B and a carry-in of 1, so the cell computes A + ~B + 1.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sb_load
      assign sb_load[gi] = b[gi] ^ (op != SAS_OP_ADD);
    end
  endgenerate

  serial_add_sub_full_adder u_full_adder (
    .a  (sa_reg[0]),
    .b  (sb_reg[0]),
    .ci (c_reg),
    .s  (s_bit),
    .co (co_bit)
  );

  assign shift_en  = (state_reg == SAS_RUN);
  assign last_bit  = shift_en && (cnt_reg == LAST_BIT);
  assign cmsb      = c_reg;
  assign res_final = {s_bit, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SAS_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      SAS_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SAS_RUN;
        end
      end
      SAS_RUN: begin
        if (cnt_reg == LAST_BIT) begin
          state_next = SAS_FIN;
        end
      end
      SAS_FIN: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SAS_RUN;
        end else begin
          state_next = SAS_IDLE;
        end
      end
      default: state_next = SAS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg  <= '0;
      sb_reg  <= '0;
      res_reg <= '0;
      cnt_reg <= '0;
      c_reg   <= 1'b0;
    end else if (accept) begin
      sa_reg  <= a;
      sb_reg  <= sb_load;
      cnt_reg <= '0;
      c_reg   <= (op == SAS_OP_SUB);
    end else if (shift_en) begin
      sa_reg  <= {1'b0, sa_reg[WIDTH-1:1]};
      sb_reg  <= {1'b0, sb_reg[WIDTH-1:1]};
      res_reg <= res_final;
      cnt_reg <= cnt_reg + CNT_W'(1);
      c_reg   <= co_bit;
    end
  end

  // Outputs move only on the completion edge, so the ALU mux sees a stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg    <= '0;
      co_reg   <= 1'b0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else if (last_bit) begin
      y_reg    <= res_final;
      co_reg   <= co_bit;
      ovf_reg  <= cmsb ^ co_bit;
      zero_reg <= ~|res_final;
    end
  end

  assign busy = (state_reg == SAS_RUN);
  assign done = (state_reg == SAS_FIN);
  assign y    = y_reg;
  assign co   = co_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

  a_busy_done_exclusive : assert property (@(posedge clk) disable iff (rst) !(busy && done));

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: directed arithmetic, handshake, reset and random runs.
module tb_serial_add_sub;
  import serial_add_sub_pkg::*;

  localparam int W       = DATA_WIDTH;
  localparam int TIMEOUT = W + 8;

  typedef struct packed {
    logic [W-1:0] y;
    logic         co;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct packed {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] a, b, y;
  logic         busy, done, co, ovf, zero;

  res_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .co    (co),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] z);
    logic [W:0] sum;
    res_t       r;
    if (o == SAS_OP_SUB) begin
      sum   = {1'b0, x} + {1'b0, ~z} + (W+1)'(1);
      r.ovf = (x[W-1] != z[W-1]) && (sum[W-1] != x[W-1]);
    end else begin
      sum   = {1'b0, x} + {1'b0, z};
      r.ovf = (x[W-1] == z[W-1]) && (sum[W-1] != x[W-1]);
    end
    r.y    = sum[W-1:0];
    r.co   = sum[W];
    r.zero = (sum[W-1:0] == '0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single edge, queue its expectation, then scramble inputs.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] z, input res_t e);
    op    = o;
    a     = x;
    b     = z;
    start = 1'b1;
    sb_q.push_back(e);
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output bit seen, output int cycles, output bit stable);
    logic [W-1:0] y0;
    y0     = y;
    seen   = 1'b0;
    cycles = 0;
    stable = 1'b1;
    while (!seen && cycles < TIMEOUT) begin
      tick();
      cycles++;
      if (done) seen = 1'b1;
      else if (y !== y0) stable = 1'b0;
    end
  endtask

  task automatic test_reset();
    res_t e;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, y, co, ovf, zero} !== '0)
      $display("FAIL reset_state got=%h want=0", {busy, done, y, co, ovf, zero});
    if ({busy, done, y, co, ovf, zero} !== '0) failures++;
    // Reset and start together: reset wins and the request is dropped.
    rst = 1'b1; start = 1'b1; op = 1'b0; a = 32'd7; b = 32'd9;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL rst_start_drop busy=%b done=%b want busy=0 done=0", busy, done);
      failures++;
    end
    e = '0;
    $display("test_reset: rst_start busy=%b y=%h", busy, y);
  endtask

  task automatic run_directed(input string name, input vec_t v);
    bit   seen, stable;
    int   cyc;
    res_t e;
    issue(v.op, v.a, v.b, v.exp);
    wait_done(seen, cyc, stable);
    e = sb_q.pop_front();
    checks++;
    if (!seen) begin
      $display("FAIL %s_timeout got no DONE in %0d cycles want DONE", name, cyc);
      failures++;
    end else begin
      checks++;
      if ({y, co, ovf, zero} !== e) begin
        $display("FAIL %s_result got y=%h co=%b ovf=%b zero=%b want y=%h co=%b ovf=%b zero=%b",
                 name, y, co, ovf, zero, e.y, e.co, e.ovf, e.zero);
        failures++;
      end
      checks++;
      if (cyc != W) begin
        $display("FAIL %s_latency got=%0d want=%0d", name, cyc, W);
        failures++;
      end
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL %s_done_width got done=%b want 0", name, done);
      failures++;
    end
    $display("%s: op=%b a=%h b=%h y=%h co=%b ovf=%b zero=%b cycles=%0d", name, v.op, v.a, v.b, y, co, ovf, zero, cyc);
  endtask

  task automatic test_add();
    vec_t tbl[3];
    tbl[0] = '{op: 1'b0, a: 32'd5,          b: 32'd3, exp: '{y: 32'd8,          co: 1'b0, ovf: 1'b0, zero: 1'b0}};
    tbl[1] = '{op: 1'b0, a: 32'h7FFF_FFFF, b: 32'd1, exp: '{y: 32'h8000_0000, co: 1'b0, ovf: 1'b1, zero: 1'b0}};
    tbl[2] = '{op: 1'b0, a: 32'hFFFF_FFFF, b: 32'd1, exp: '{y: 32'h0,          co: 1'b1, ovf: 1'b0, zero: 1'b1}};
    for (int i = 0; i < 3; i++) run_directed("add", tbl[i]);
  endtask

  task automatic test_sub();
    vec_t tbl[3];
    tbl[0] = '{op: 1'b1, a: 32'd5,          b: 32'd5, exp: '{y: 32'h0,          co: 1'b1, ovf: 1'b0, zero: 1'b1}};
    tbl[1] = '{op: 1'b1, a: 32'd3,          b: 32'd5, exp: '{y: 32'hFFFF_FFFE, co: 1'b0, ovf: 1'b0, zero: 1'b0}};
    tbl[2] = '{op: 1'b1, a: 32'h8000_0000, b: 32'd1, exp: '{y: 32'h7FFF_FFFF, co: 1'b1, ovf: 1'b1, zero: 1'b0}};
    for (int i = 0; i < 3; i++) run_directed("sub", tbl[i]);
  endtask

  task automatic test_busy_ignore();
    bit   seen, stable;
    int   cyc;
    res_t e;
    issue(1'b0, 32'd100, 32'd23, model(1'b0, 32'd100, 32'd23));
    repeat (3) tick();
    start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0;
    wait_done(seen, cyc, stable);
    e = sb_q.pop_front();
    checks++;
    if (!seen) begin
      $display("FAIL busy_ignore_timeout got no DONE want DONE");
      failures++;
    end else begin
      checks++;
      if ({y, co, ovf, zero} !== e) begin
        $display("FAIL busy_ignore_result got y=%h co=%b ovf=%b zero=%b want y=%h co=%b ovf=%b zero=%b",
                 y, co, ovf, zero, e.y, e.co, e.ovf, e.zero);
        failures++;
      end
      checks++;
      if (cyc != W - 4) begin
        $display("FAIL busy_ignore_latency got=%0d want=%0d", cyc, W - 4);
        failures++;
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL busy_ignore_relaunch got busy=%b want 0", busy);
      failures++;
    end
    $display("busy_ignore: y=%h cycles=%0d", y, cyc);
  endtask

  task automatic test_back_to_back();
    bit   seen, stable;
    int   cyc;
    res_t e;
    issue(1'b0, 32'h1234_5678, 32'h1111_1111, model(1'b0, 32'h1234_5678, 32'h1111_1111));
    wait_done(seen, cyc, stable);
    e = sb_q.pop_front();
    checks++;
    if (!seen || {y, co, ovf, zero} !== e) begin
      $display("FAIL b2b_first got seen=%b y=%h want y=%h", seen, y, e.y);
      failures++;
    end
    issue(1'b1, 32'h0000_0010, 32'h0000_0020, model(1'b1, 32'h0000_0010, 32'h0000_0020));
    wait_done(seen, cyc, stable);
    e = sb_q.pop_front();
    checks++;
    if (!seen || cyc + 1 != W + 1) begin
      $display("FAIL b2b_spacing got seen=%b spacing=%0d want %0d", seen, cyc + 1, W + 1);
      failures++;
    end
    checks++;
    if ({y, co, ovf, zero} !== e) begin
      $display("FAIL b2b_second got y=%h co=%b ovf=%b zero=%b want y=%h co=%b ovf=%b zero=%b",
               y, co, ovf, zero, e.y, e.co, e.ovf, e.zero);
      failures++;
    end
    tick();
    $display("back_to_back: y=%h spacing=%0d", e.y, cyc + 1);
  endtask

  task automatic test_reset_mid_run();
    bit   seen, stable, any_done;
    int   cyc;
    res_t e;
    issue(1'b0, 32'd1234, 32'd4321, model(1'b0, 32'd1234, 32'd4321));
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb_q.pop_back());
    checks++;
    if ({busy, done, y, co, ovf, zero} !== '0) begin
      $display("FAIL midrun_reset_state got=%h want=0", {busy, done, y, co, ovf, zero});
      failures++;
    end
    any_done = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done) any_done = 1'b1;
    end
    checks++;
    if (any_done) begin
      $display("FAIL midrun_no_done got done pulse want none");
      failures++;
    end
    issue(1'b1, 32'd50, 32'd8, model(1'b1, 32'd50, 32'd8));
    wait_done(seen, cyc, stable);
    e = sb_q.pop_front();
    checks++;
    if (!seen || {y, co, ovf, zero} !== e) begin
      $display("FAIL midrun_restart got seen=%b y=%h co=%b want y=%h co=%b", seen, y, co, e.y, e.co);
      failures++;
    end
    tick();
    $display("reset_mid_run: restart y=%h", y);
  endtask

  task automatic test_random();
    bit           seen, stable;
    int           cyc;
    res_t         e;
    logic         o;
    logic [W-1:0] x, z;
    for (int n = 0; n < 1000; n++) begin
      o = 1'($urandom_range(0, 1));
      x = $urandom;
      z = $urandom;
      case ($urandom_range(0, 9))
        0: x = '0;
        1: z = '1;
        2: z = x;
        3: x = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      issue(o, x, z, model(o, x, z));
      wait_done(seen, cyc, stable);
      e = sb_q.pop_front();
      checks++;
      if (!seen) begin
        $display("FAIL rand_timeout n=%0d got no DONE want DONE", n);
        failures++;
      end else begin
        checks++;
        if ({y, co, ovf, zero} !== e) begin
          $display("FAIL rand_result n=%0d op=%b a=%h b=%h got y=%h co=%b ovf=%b zero=%b want y=%h co=%b ovf=%b zero=%b",
                   n, o, x, z, y, co, ovf, zero, e.y, e.co, e.ovf, e.zero);
          failures++;
        end
        checks++;
        if (!stable) begin
          $display("FAIL rand_stable n=%0d got y changed before DONE want stable", n);
          failures++;
        end
      end
      $display("rand %0d: op=%b a=%h b=%h y=%h co=%b ovf=%b zero=%b", n, o, x, z, y, co, ovf, zero);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    test_reset();
    test_add();
    test_sub();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
